// File: rtl/tp2_pkg.sv
// rtl/tp2_pkg.sv - shared class codes, FSM states and segment patterns for the tp2 result collector
package tp2_pkg;

    // Word class codes as produced by the classifier {out1,out2}
    localparam logic [1:0] CLS_ERR  = 2'b00;
    localparam logic [1:0] CLS_ADJ  = 2'b01;
    localparam logic [1:0] CLS_COMP = 2'b10;
    localparam logic [1:0] CLS_ADV  = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        HOLD     = 3'd2,
        CLEAR    = 3'd3,
        WAIT_LOW = 3'd4
    } state_e;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_decode(input logic [1:0] cls);
        logic [6:0] pat;
        case (cls)
            CLS_ADJ:  pat = SEG_A;
            CLS_COMP: pat = SEG_C;
            CLS_ADV:  pat = SEG_D;
            default:  pat = SEG_E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/tp2_sat_counter.sv
// rtl/tp2_sat_counter.sv - saturating up-counter with synchronous clear taking priority over increment
module tp2_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Clear beats increment; increment stops at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tp2_result_collector.sv
// rtl/tp2_result_collector.sv - latches classifier results, counts per class, pulses classifier clear (optional TP2_SEG_DISPLAY_EN)
module tp2_result_collector
    import tp2_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             out1,
    input  logic             out2,
    input  logic             fim,
    input  logic             clear_cnt,
    output logic [1:0]       word_class,
    output logic             class_valid,
    output logic             clr_req,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] cnt_adj,
    output logic [CNT_W-1:0] cnt_comp,
    output logic [CNT_W-1:0] cnt_adv,
    output logic [6:0]       seg
);

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    state_e     state_q;
    state_e     state_d;
    logic       fim_q;
    logic       fim_rise;
    logic [7:0] timer_q;
    logic [3:0] inc_vec;

    // fim_q resets high so a done flag already asserted at reset release is not mistaken for a new word
    assign fim_rise = fim & ~fim_q;

    // State register and done-flag history
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            fim_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            fim_q   <= fim;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d     = state_q;
        class_valid = 1'b0;
        clr_req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fim_rise) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                class_valid = 1'b1;
                if (timer_q == 8'd0) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_req = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!fim) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Class latch and hold timer; timer is loaded so HOLD lasts exactly HOLD_CYCLES cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_class <= CLS_ERR;
            timer_q    <= 8'd0;
        end else if (state_q == CAPTURE) begin
            word_class <= {out1, out2};
            timer_q    <= HOLD_M1;
        end else if ((state_q == HOLD) && (timer_q != 8'd0)) begin
            timer_q <= timer_q - 8'd1;
        end
    end

    assign inc_vec = (state_q == CAPTURE) ? (4'b0001 << {out1, out2}) : 4'b0000;

    tp2_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
        .clock (clock), .reset (reset), .inc (inc_vec[0]), .clr (clear_cnt), .count (cnt_err)
    );
    tp2_sat_counter #(.CNT_W(CNT_W)) u_cnt_adj (
        .clock (clock), .reset (reset), .inc (inc_vec[1]), .clr (clear_cnt), .count (cnt_adj)
    );
    tp2_sat_counter #(.CNT_W(CNT_W)) u_cnt_comp (
        .clock (clock), .reset (reset), .inc (inc_vec[2]), .clr (clear_cnt), .count (cnt_comp)
    );
    tp2_sat_counter #(.CNT_W(CNT_W)) u_cnt_adv (
        .clock (clock), .reset (reset), .inc (inc_vec[3]), .clr (clear_cnt), .count (cnt_adv)
    );

`ifdef TP2_SEG_DISPLAY_EN
    logic ever_q;

    // Remembers that at least one word was captured so the display stays blank until then
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ever_q <= 1'b0;
        end else if (state_q == CAPTURE) begin
            ever_q <= 1'b1;
        end
    end

    assign seg = ever_q ? seg_decode(word_class) : SEG_BLANK;
`else
    assign seg = SEG_BLANK;
`endif

endmodule

// File: tb/tb_tp2_result_collector.sv
// tb/tb_tp2_result_collector.sv - randomized self-checking bench for tp2_result_collector
module tb_tp2_result_collector;

    localparam int CNT_W = 4;
    localparam int H     = 8;
    localparam int CMAX  = 15;

`ifdef TP2_SEG_DISPLAY_EN
    localparam int EXP_SEG_E = 7'b1111001;
    localparam int EXP_SEG_C = 7'b0111001;
`else
    localparam int EXP_SEG_E = 0;
    localparam int EXP_SEG_C = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             out1 = 1'b0;
    logic             out2 = 1'b0;
    logic             fim = 1'b1;
    logic             clear_cnt = 1'b0;
    logic [1:0]       word_class;
    logic             class_valid;
    logic             clr_req;
    logic [CNT_W-1:0] cnt_err;
    logic [CNT_W-1:0] cnt_adj;
    logic [CNT_W-1:0] cnt_comp;
    logic [CNT_W-1:0] cnt_adv;
    logic [6:0]       seg;

    tp2_result_collector #(.CNT_W(CNT_W), .HOLD_CYCLES(H)) dut (
        .clock       (clock),
        .reset       (reset),
        .out1        (out1),
        .out2        (out2),
        .fim         (fim),
        .clear_cnt   (clear_cnt),
        .word_class  (word_class),
        .class_valid (class_valid),
        .clr_req     (clr_req),
        .cnt_err     (cnt_err),
        .cnt_adj     (cnt_adj),
        .cnt_comp    (cnt_comp),
        .cnt_adv     (cnt_adv),
        .seg         (seg)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_seg(input bit ever, input int cls);
        int r;
        r = 0;
`ifdef TP2_SEG_DISPLAY_EN
        if (ever) begin
            case (cls)
                0:       r = 7'b1111001;
                1:       r = 7'b1110111;
                2:       r = 7'b0111001;
                default: r = 7'b1011110;
            endcase
        end
`else
        if (ever && cls > 3) r = 0;
`endif
        return r;
    endfunction

    // Reference model: a word is a timeline anchored at the edge where its class lands.
    // valid spans H cycles from that edge, the clear pulse follows, then the collector
    // re-arms once fim is seen low.
    int edge_n;
    int cap_edge;
    bit m_idle;
    bit m_prev_fim;
    bit m_ever;
    int m_cnt[4];
    int m_class;
    int m_valid;
    int m_clr;

    task automatic model_reset();
        edge_n     = 0;
        cap_edge   = -1000;
        m_idle     = 1'b1;
        m_prev_fim = 1'b1;
        m_ever     = 1'b0;
        m_class    = 0;
        m_valid    = 0;
        m_clr      = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        int cls;
        cls = int'({out1, out2});
        edge_n++;
        if (m_idle && fim && !m_prev_fim) begin
            m_idle   = 1'b0;
            cap_edge = edge_n + 1;
        end
        if (edge_n == cap_edge) begin
            m_class = cls;
            m_ever  = 1'b1;
        end
        if (clear_cnt) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (edge_n == cap_edge && m_cnt[cls] < CMAX) begin
            m_cnt[cls]++;
        end
        if (!m_idle && edge_n >= cap_edge + H + 2 && !fim) m_idle = 1'b1;
        m_prev_fim = fim;
        m_valid = (edge_n >= cap_edge && edge_n < cap_edge + H) ? 1 : 0;
        m_clr   = (edge_n == cap_edge + H) ? 1 : 0;
    endtask

    initial begin
        forever begin
            if (!reset) model_reset();
            else        model_step();
            @(posedge clock or negedge reset);
        end
    end

    // Compare every cycle away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("word_class",  int'(word_class),  m_class);
                check("class_valid", int'(class_valid), m_valid);
                check("clr_req",     int'(clr_req),     m_clr);
                check("cnt_err",     int'(cnt_err),     m_cnt[0]);
                check("cnt_adj",     int'(cnt_adj),     m_cnt[1]);
                check("cnt_comp",    int'(cnt_comp),    m_cnt[2]);
                check("cnt_adv",     int'(cnt_adv),     m_cnt[3]);
                check("seg",         int'(seg),         exp_seg(m_ever, m_class));
            end
        end
    end

    task automatic do_reset(input bit fim_level);
        @(negedge clock);
        #1;
        reset = 1'b0;
        fim = fim_level;
        clear_cnt = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_word(input int cls, input bit clr_cap, output int vc, output int cc);
        bit seen;
        seen = 1'b0;
        vc = 0;
        cc = 0;
        @(negedge clock);
        #1;
        {out1, out2} = 2'(cls);
        fim = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            vc += int'(class_valid);
            cc += int'(clr_req);
            if (clr_req) seen = 1'b1;
            #1;
            clear_cnt = clr_cap && (i == 0);
            if (i > 0) {out1, out2} = 2'($urandom_range(0, 3));
        end
        check("word_done", int'(seen), 1);
        fim = 1'b0;
        clear_cnt = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    int vc;
    int cc;

    initial begin
        // Test 1: fim high across reset release is not a new word
        reset = 1'b0;
        fim = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        vc = 0;
        cc = 0;
        repeat (20) begin
            @(negedge clock);
            vc += int'(class_valid);
            cc += int'(clr_req);
        end
        check("t1_valid_cycles", vc, 0);
        check("t1_clr_pulses", cc, 0);
        check("t1_counters", int'(cnt_err) + int'(cnt_adj) + int'(cnt_comp) + int'(cnt_adv), 0);
        check("t1_seg", int'(seg), 0);
        #1;
        fim = 1'b0;
        repeat (2) @(negedge clock);

        // Test 2: single ADJ word
        do_word(1, 1'b0, vc, cc);
        check("t2_valid_cycles", vc, 8);
        check("t2_clr_pulses", cc, 1);
        check("t2_cnt_adj", int'(cnt_adj), 1);
        check("t2_word_class", int'(word_class), 1);

        // Test 3 and 6: one word of each class, display tracks the last class
        do_reset(1'b0);
        check("t6_seg_reset", int'(seg), 0);
        do_word(0, 1'b0, vc, cc);
        check("t6_seg_err", int'(seg), EXP_SEG_E);
        do_word(2, 1'b0, vc, cc);
        check("t6_seg_comp", int'(seg), EXP_SEG_C);
        do_word(3, 1'b0, vc, cc);
        do_word(1, 1'b0, vc, cc);
        check("t3_cnt_err", int'(cnt_err), 1);
        check("t3_cnt_comp", int'(cnt_comp), 1);
        check("t3_cnt_adv", int'(cnt_adv), 1);
        check("t3_cnt_adj", int'(cnt_adj), 1);
        check("t3_word_class", int'(word_class), 1);

        // Test 4: saturation
        do_reset(1'b0);
        repeat (20) do_word(3, 1'b0, vc, cc);
        check("t4_cnt_adv_sat", int'(cnt_adv), 15);
        check("t4_others", int'(cnt_err) + int'(cnt_adj) + int'(cnt_comp), 0);

        // Test 5: clear during capture beats the increment
        do_reset(1'b0);
        do_word(0, 1'b0, vc, cc);
        do_word(1, 1'b0, vc, cc);
        do_word(0, 1'b1, vc, cc);
        check("t5_cnt_err", int'(cnt_err), 0);
        check("t5_cnt_adj", int'(cnt_adj), 0);
        check("t5_word_class", int'(word_class), 0);

        // Test 5b: async reset in the middle of HOLD
        @(negedge clock);
        #1;
        {out1, out2} = 2'b10;
        fim = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_in_hold", int'(class_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        check("t5_async_valid", int'(class_valid), 0);
        check("t5_async_clr", int'(clr_req), 0);
        check("t5_async_class", int'(word_class), 0);
        check("t5_async_cnt", int'(cnt_err) + int'(cnt_adj) + int'(cnt_comp) + int'(cnt_adv), 0);
        check("t5_async_seg", int'(seg), 0);
        fim = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Randomized words with occasional clears
        for (int w = 0; w < 30; w++) begin
            do_word(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), vc, cc);
        end

        // Fully random input activity
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            #1;
            if ($urandom_range(0, 5) == 0) fim = ~fim;
            {out1, out2} = 2'($urandom_range(0, 3));
            clear_cnt = ($urandom_range(0, 19) == 0);
        end
        @(negedge clock);
        #1;
        clear_cnt = 1'b0;
        fim = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
